// File: rtl/mca_pkg.sv
// Shared definitions for the multiply-accumulate dot-product block.
//  - Default operand and accumulator widths.
//  - mca_ovf: overflow detection for an ACC_W-bit add, given the operand
//    sign bits, the result sign bit and the carry out of the top bit.
package mca_pkg;

  localparam int MCA_DATA_W = 8;
  localparam int MCA_ACC_W  = 24;

  // Unsigned: the add overflowed when it carried out of the top bit.
  // Signed: two operands of equal sign produced a result of the other sign.
  function automatic logic mca_ovf(input logic sgn,
                                   input logic a_msb,
                                   input logic b_msb,
                                   input logic s_msb,
                                   input logic carry);
    if (sgn) return (a_msb == b_msb) && (s_msb != a_msb);
    return carry;
  endfunction

endpackage

// File: rtl/mca_sat_acc.sv
// Combinational ACC_W-bit adder with overflow flag and optional saturation.
// Ports:
//  a, b  in   ACC_W  addends (two's complement when SIGNED=1)
//  sum   out  ACC_W  clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//  ovf   out  1      the exact sum does not fit in ACC_W bits
module mca_sat_acc
  import mca_pkg::*;
#(
  parameter int ACC_W    = MCA_ACC_W,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] raw;
  logic           ext_a;
  logic           ext_b;

  // On overflow the direction is given by the operand sign: two positives
  // overflow upwards, two negatives downwards. Unsigned only overflows upwards.
  function automatic logic [ACC_W-1:0] clamp(input logic [ACC_W-1:0] wrapped,
                                             input logic             over,
                                             input logic             a_msb);
    if (!over || (SATURATE == 0)) return wrapped;
    if (SIGNED == 0) return '1;
    if (a_msb) return {1'b1, {(ACC_W-1){1'b0}}};
    return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  always_comb begin
    ext_a = (SIGNED != 0) ? a[ACC_W-1] : 1'b0;
    ext_b = (SIGNED != 0) ? b[ACC_W-1] : 1'b0;
    raw   = {ext_a, a} + {ext_b, b};
    ovf   = mca_ovf(SIGNED != 0, a[ACC_W-1], b[ACC_W-1], raw[ACC_W-1], raw[ACC_W]);
    sum   = clamp(raw[ACC_W-1:0], ovf, a[ACC_W-1]);
  end

endmodule

// File: rtl/mca_dot_pipe.sv
// Pipelined dot-product engine: multiplies (a,b) pairs in stage 1 and
// accumulates them in stage 2 over VEC_LEN terms (or fewer when in_last is
// set), presenting one result beat per vector with an overflow flag.
// Ports:
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous active-low reset
//  clear      in   1        sync flush of partial vector and stage-1 product
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        pair accepted this cycle
//  in_a/in_b  in   DATA_W   operands
//  in_last    in   1        pair closes the vector
//  out_valid  out  1        result held
//  out_ready  in   1        consumer takes the result
//  out_data   out  ACC_W    dot product
//  out_ovf    out  1        overflow occurred within the vector
//  out_count  out  CNT_W    number of terms in the result
module mca_dot_pipe
  import mca_pkg::*;
#(
  parameter int DATA_W   = MCA_DATA_W,
  parameter int ACC_W    = MCA_ACC_W,
  parameter int VEC_LEN  = 4,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

  localparam int PROD_W = 2 * DATA_W;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_acc_w_chk
      $error("mca_dot_pipe: ACC_W must be >= 2*DATA_W");
    end
    if (VEC_LEN < 1) begin : g_vec_len_chk
      $error("mca_dot_pipe: VEC_LEN must be >= 1");
    end
  endgenerate

  logic adv;

  logic               [PROD_W-1:0] prod_u_p0;
  logic signed        [PROD_W-1:0] prod_s_p0;
  logic               [PROD_W-1:0] prod_p0;

  logic [PROD_W-1:0] prod_p1;
  logic              vld_p1;
  logic              last_p1;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;

  logic [ACC_W-1:0] prod_ext_p1;
  logic [ACC_W-1:0] acc_in_p1;
  logic [ACC_W-1:0] sum_p1;
  logic             ovf_p1;
  logic             vec_end_p1;
  logic             load_p2;

  // A held, unconsumed result freezes the whole pipeline.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // ---- stage 0: operand multiply ----
  always_comb begin
    prod_u_p0 = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
    prod_s_p0 = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
                $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
    prod_p0   = (SIGNED != 0) ? prod_s_p0 : prod_u_p0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
    end else if (adv) begin
      prod_p1 <= prod_p0;
      vld_p1  <= in_valid;
      last_p1 <= in_last;
    end
  end

  // ---- stage 1: accumulate ----
  always_comb begin
    prod_ext_p1 = ((SIGNED != 0) && prod_p1[PROD_W-1]) ? '1 : '0;
    prod_ext_p1[PROD_W-1:0] = prod_p1;
    acc_in_p1   = (cnt == '0) ? '0 : acc;
    vec_end_p1  = last_p1 || (cnt == CNT_W'(VEC_LEN - 1));
    load_p2     = adv && vld_p1 && vec_end_p1 && !clear;
  end

  mca_sat_acc #(
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_acc (
    .a   (acc_in_p1),
    .b   (prod_ext_p1),
    .sum (sum_p1),
    .ovf (ovf_p1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (adv && vld_p1) begin
      if (vec_end_p1) begin
        cnt     <= '0;
        acc     <= '0;
        ovf_acc <= 1'b0;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        acc     <= sum_p1;
        ovf_acc <= ovf_acc | ovf_p1;
      end
    end
  end

  // ---- stage 2: result register ----
  // A new result may load on the same edge the previous one is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (load_p2) begin
      out_valid <= 1'b1;
      out_data  <= sum_p1;
      out_ovf   <= ovf_acc | ovf_p1;
      out_count <= cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mca_dot_pipe.sv
// Bench for mca_dot_pipe: four instances (default, 16-bit saturating,
// 16-bit wrapping, signed) share one stimulus stream; each has its own
// reference accumulator and result queue.
module tb_mca_dot_pipe;

  localparam int N = 4;
  localparam int W[N]  = '{24, 16, 16, 24};
  localparam bit SG[N] = '{0, 0, 0, 1};
  localparam bit ST[N] = '{1, 1, 0, 1};

  typedef struct {
    longint data;
    bit     ovf;
    int     cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       out_ready;

  logic        ir[N];
  logic        ov[N];
  logic        oovf[N];
  logic [2:0]  ocnt[N];
  logic [23:0] od0;
  logic [15:0] od1;
  logic [15:0] od2;
  logic [23:0] od3;

  int n_chk = 0;
  int n_err = 0;

  exp_t   sb[N][$];
  longint m_acc[N];
  int     m_cnt[N];
  bit     m_ovf[N];

  always #5 clk = ~clk;

  mca_dot_pipe #(.DATA_W(8), .ACC_W(24), .VEC_LEN(4), .SIGNED(0), .SATURATE(1)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od0), .out_ovf(oovf[0]), .out_count(ocnt[0]));

  mca_dot_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(4), .SIGNED(0), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .out_ovf(oovf[1]), .out_count(ocnt[1]));

  mca_dot_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(4), .SIGNED(0), .SATURATE(0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .out_ovf(oovf[2]), .out_count(ocnt[2]));

  mca_dot_pipe #(.DATA_W(8), .ACC_W(24), .VEC_LEN(4), .SIGNED(1), .SATURATE(1)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir[3]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od3), .out_ovf(oovf[3]), .out_count(ocnt[3]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint got_data(input int k);
    case (k)
      0:       return longint'(od0);
      1:       return longint'(od1);
      2:       return longint'(od2);
      default: return longint'(od3);
    endcase
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  // Exact arithmetic in 64 bits, then range-check against the ACC_W limits.
  function automatic void model_pair(input int k, input logic [7:0] a,
                                     input logic [7:0] b, input logic last);
    longint pa, pb, s, lo, hi, span;
    bit     o;
    exp_t   e;
    span = longint'(1) <<< W[k];
    pa   = SG[k] ? longint'(signed'(a)) : longint'(a);
    pb   = SG[k] ? longint'(signed'(b)) : longint'(b);
    lo   = SG[k] ? -(span / 2) : 0;
    hi   = SG[k] ? (span / 2) - 1 : span - 1;
    s    = m_acc[k] + pa * pb;
    o    = (s < lo) || (s > hi);
    if (o) begin
      if (ST[k]) s = (s < lo) ? lo : hi;
      else begin
        s = s & (span - 1);
        if (s > hi) s = s - span;
      end
    end
    m_ovf[k] = m_ovf[k] | o;
    m_cnt[k] = m_cnt[k] + 1;
    if (last || m_cnt[k] == 4) begin
      e.data = s & (span - 1);
      e.ovf  = m_ovf[k];
      e.cnt  = m_cnt[k];
      sb[k].push_back(e);
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end else begin
      m_acc[k] = s;
    end
  endfunction

  // Inputs change 1 time unit after posedge; everything is observed at negedge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) sb[k].delete();
      model_clear();
    end else begin
      if (clear) model_clear();
      else if (in_valid && ir[0])
        for (int k = 0; k < N; k++) model_pair(k, in_a, in_b, in_last);
      for (int k = 0; k < N; k++) begin
        if (ov[k] && out_ready) begin
          if (sb[k].size() == 0) begin
            check($sformatf("unexpected_result_d%0d", k), 1, 0);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            check($sformatf("data_d%0d", k), got_data(k), e.data);
            check($sformatf("ovf_d%0d", k), longint'(oovf[k]), longint'(e.ovf));
            check($sformatf("count_d%0d", k), longint'(ocnt[k]), longint'(e.cnt));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit got;
    int n;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ir[0];
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(ov[0]), 0);
    check("rst_out_data", longint'(od0), 0);
    check("rst_out_ovf", longint'(oovf[0]), 0);
    check("rst_out_count", longint'(ocnt[0]), 0);
    check("rst_in_ready", longint'(ir[0]), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Full vector, with redundant in_last on the 4th term; latency check.
    send(8'd170, 8'd204, 1'b0);
    send(8'd42, 8'd204, 1'b0);
    send(8'd42, 8'd79, 1'b0);
    send(8'd47, 8'd124, 1'b1);
    check("lat_after_accept", longint'(ov[0]), 0);
    idle(1);
    check("lat_next_edge", longint'(ov[0]), 1);
    check("lat_data", longint'(od0), 52394);
    idle(3);

    // Short vector, then a full one without in_last.
    send(8'd3, 8'd5, 1'b0);
    send(8'd7, 8'd11, 1'b1);
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b0);
    idle(4);

    // Backpressure: result held for 5 cycles while the next vector waits.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'd10, 8'd10, 1'b0);
        for (int i = 1; i <= 4; i++) send(8'(i), 8'd3, i == 4);
      end
      begin
        logic [23:0] held;
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ov[0] && n < 50);
        check("hold_reached", longint'(ov[0]), 1);
        held = od0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("hold_in_ready", longint'(ir[0]), 0);
          check("hold_valid", longint'(ov[0]), 1);
          check("hold_data", longint'(od0), longint'(held));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // Overflow: saturate vs wrap on the 16-bit instances.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle(4);

    // Signed extremes.
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h7f, 1'b0);
    send(8'h00, 8'h00, 1'b0);
    send(8'h00, 8'h00, 1'b0);
    idle(4);

    // Clear discards a partial vector.
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    idle(3);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
    idle(4);

    // Async reset with a held result and a term in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd5, 8'd5, 1'b0);
    send(8'd6, 8'd6, 1'b0);
    idle(2);
    check("pre_reset_valid", longint'(ov[0]), 1);
    #2 reset = 1'b0;
    #1;
    check("areset_out_valid", longint'(ov[0]), 0);
    check("areset_out_data", longint'(od0), 0);
    check("areset_out_ovf", longint'(oovf[0]), 0);
    check("areset_out_count", longint'(ocnt[0]), 0);
    check("areset_in_ready", longint'(ir[0]), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(8'd2, 8'd3, 1'b0);
    idle(5);

    for (int k = 0; k < N; k++)
      check($sformatf("sb_empty_d%0d", k), longint'(sb[k].size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
